// File: rtl/zbt_tx_pkg.sv
// Shared types and constants for the ZBT-to-Ethernet transmit streamer.
package zbt_tx_pkg;

    localparam int ADDR_W = 24;
    localparam int DATA_W = 32;
    localparam int AW1    = ADDR_W + 1;

    localparam int DEF_PKT_WORDS   = 256;
    localparam int DEF_FIFO_DEPTH  = 8;
    localparam int DEF_ZBT_LATENCY = 2;
    localparam int DEF_GAP_CYCLES  = 1024;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_SEND,
        ST_DRAIN,
        ST_GAP
    } tx_state_e;

    // Last address of a packet starting at 'first', clipped to the range end.
    function automatic logic [ADDR_W-1:0] pkt_last(input logic [ADDR_W-1:0] first,
                                                   input logic [ADDR_W-1:0] last,
                                                   input int words);
        logic [AW1-1:0] lim;
        lim = {1'b0, first} + AW1'(words - 1);
        return (lim > {1'b0, last}) ? last : lim[ADDR_W-1:0];
    endfunction

endpackage

// File: rtl/zbt_tx_fifo.sv
// Prefetch FIFO between ZBT read data and the Ethernet transmitter.
// Head reads as zero when empty; flush discards contents and any same-cycle push.
module zbt_tx_fifo
    import zbt_tx_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop & ~empty & ~flush;
    assign do_push = push & (~full | do_pop) & ~flush;
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/zbt_eth_tx_streamer.sv
// Streams a ZBT word range to the Ethernet transmitter as gap-separated packets.
// Optional running sum of transmitted words when ZBT_TX_CHECKSUM_EN is defined.
//
// state | meaning
// IDLE  | waiting for Start_I; read data ignored
// FILL  | prefetching the packet head into the FIFO
// SEND  | Start_send_O issued, waiting for Active_tx_I
// DRAIN | transmitter busy, FIFO kept topped up
// GAP   | inter-packet idle time, then next packet or Done_O
module zbt_eth_tx_streamer
    import zbt_tx_pkg::*;
#(
    parameter int PKT_WORDS   = DEF_PKT_WORDS,
    parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
    parameter int ZBT_LATENCY = DEF_ZBT_LATENCY,
    parameter int GAP_CYCLES  = DEF_GAP_CYCLES
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              Start_I,
    input  logic [ADDR_W-1:0] Range_begin_I,
    input  logic [ADDR_W-1:0] Range_end_I,
    output logic              Busy_O,
    output logic              Done_O,
    output logic              Error_O,
    input  logic              ZBT_ready_I,
    output logic              Read_req_O,
    output logic [ADDR_W-1:0] Address_O,
    input  logic [DATA_W-1:0] Read_data_I,
    input  logic              Read_valid_I,
    output logic              Start_send_O,
    output logic [ADDR_W-1:0] Pkt_begin_O,
    output logic [ADDR_W-1:0] Pkt_end_O,
    output logic [DATA_W-1:0] TX_data_O,
    input  logic              TX_read_ack_I,
    input  logic              Active_tx_I,
    input  logic              TX_error_I
`ifdef ZBT_TX_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] Checksum_O
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int OUT_W = $clog2(FIFO_DEPTH + ZBT_LATENCY + 1);
    localparam int OCC_W = OUT_W + 1;
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    tx_state_e         state;
    tx_state_e         state_nx;
    logic [AW1-1:0]    rd_addr;
    logic [ADDR_W-1:0] pkt_begin;
    logic [ADDR_W-1:0] pkt_end;
    logic [ADDR_W-1:0] range_end;
    logic [OUT_W-1:0]  outstanding;
    logic [GAP_W-1:0]  gap_cnt;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_head;
    logic [OCC_W-1:0]  occupancy;
    logic [AW1-1:0]    pkt_len;
    logic [AW1-1:0]    fill_thr;
    logic              active;
    logic              push;
    logic              pop;
    logic              underrun;
    logic              abort;
    logic              read_acc;
    logic              fill_done;
    logic              gap_end;
    logic              start_ok;
    logic              start_bad;
    logic              send_go;
    logic              done_go;
    logic              next_pkt;

    assign active    = (state != ST_IDLE);
    // Valid data with nothing outstanding belongs to an aborted transfer.
    assign push      = active & Read_valid_I & (outstanding != '0);
    assign pop       = active & TX_read_ack_I & ~fifo_empty;
    assign underrun  = active & TX_read_ack_I & fifo_empty;
    assign abort     = active & (TX_error_I | underrun);
    assign occupancy = OCC_W'(fifo_count) + OCC_W'(outstanding);
    assign Read_req_O = active & (rd_addr <= {1'b0, pkt_end})
                        & (occupancy < OCC_W'(FIFO_DEPTH));
    assign read_acc  = Read_req_O & ZBT_ready_I;
    assign Address_O = rd_addr[ADDR_W-1:0];
    assign pkt_len   = {1'b0, pkt_end} - {1'b0, pkt_begin} + AW1'(1);
    assign fill_thr  = (pkt_len < AW1'(FIFO_DEPTH / 2)) ? pkt_len : AW1'(FIFO_DEPTH / 2);
    assign fill_done = (AW1'(fifo_count) >= fill_thr);
    assign gap_end   = (gap_cnt == GAP_W'(GAP_CYCLES - 1));
    assign Busy_O    = active;
    assign TX_data_O = fifo_head;
    assign Pkt_begin_O = pkt_begin;
    assign Pkt_end_O   = pkt_end;

    zbt_tx_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .flush     (abort),
        .push      (push),
        .push_data (Read_data_I),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        start_ok  = 1'b0;
        start_bad = 1'b0;
        send_go   = 1'b0;
        done_go   = 1'b0;
        next_pkt  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (Start_I) begin
                    if (Range_end_I < Range_begin_I) begin
                        start_bad = 1'b1;
                    end else begin
                        start_ok = 1'b1;
                        state_nx = ST_FILL;
                    end
                end
            end
            ST_FILL: begin
                if (fill_done) begin
                    send_go  = 1'b1;
                    state_nx = ST_SEND;
                end
            end
            ST_SEND: begin
                if (Active_tx_I) begin
                    state_nx = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!Active_tx_I) begin
                    state_nx = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_end) begin
                    if (pkt_end == range_end) begin
                        done_go  = 1'b1;
                        state_nx = ST_IDLE;
                    end else begin
                        next_pkt = 1'b1;
                        state_nx = ST_FILL;
                    end
                end
            end
            default: state_nx = ST_IDLE;
        endcase
        if (abort) begin
            state_nx = ST_IDLE;
            send_go  = 1'b0;
            done_go  = 1'b0;
            next_pkt = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_addr      <= '0;
            pkt_begin    <= '0;
            pkt_end      <= '0;
            range_end    <= '0;
            outstanding  <= '0;
            gap_cnt      <= '0;
            Start_send_O <= 1'b0;
            Done_O       <= 1'b0;
            Error_O      <= 1'b0;
        end else begin
            Start_send_O <= send_go;
            Done_O       <= done_go;
            Error_O      <= abort | start_bad;
            if (start_ok) begin
                rd_addr   <= {1'b0, Range_begin_I};
                pkt_begin <= Range_begin_I;
                pkt_end   <= pkt_last(Range_begin_I, Range_end_I, PKT_WORDS);
                range_end <= Range_end_I;
            end else if (next_pkt) begin
                pkt_begin <= pkt_end + ADDR_W'(1);
                pkt_end   <= pkt_last(pkt_end + ADDR_W'(1), range_end, PKT_WORDS);
            end else if (read_acc) begin
                rd_addr <= rd_addr + AW1'(1);
            end
            if (state_nx == ST_IDLE) begin
                outstanding <= '0;
            end else begin
                outstanding <= outstanding + OUT_W'(read_acc) - OUT_W'(push);
            end
            gap_cnt <= (state == ST_GAP && state_nx == ST_GAP) ? gap_cnt + GAP_W'(1) : '0;
        end
    end

`ifdef ZBT_TX_CHECKSUM_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            Checksum_O <= '0;
        end else if (state == ST_IDLE && Start_I) begin
            Checksum_O <= '0;
        end else if (pop) begin
            Checksum_O <= Checksum_O + fifo_head;
        end
    end
`endif

endmodule

// File: tb/tb_zbt_eth_tx_streamer.sv
// Directed/randomized bench for zbt_eth_tx_streamer with a ZBT memory model
// and an address-range packet model.
module tb_zbt_eth_tx_streamer;

    localparam int PKT_WORDS   = 256;
    localparam int FIFO_DEPTH  = 8;
    localparam int ZBT_LATENCY = 2;
    localparam int GAP_CYCLES  = 1024;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        Start_I = 1'b0;
    logic [23:0] Range_begin_I = '0;
    logic [23:0] Range_end_I = '0;
    logic        Busy_O, Done_O, Error_O;
    logic        ZBT_ready_I = 1'b0;
    logic        Read_req_O;
    logic [23:0] Address_O;
    logic [31:0] Read_data_I = '0;
    logic        Read_valid_I = 1'b0;
    logic        Start_send_O;
    logic [23:0] Pkt_begin_O, Pkt_end_O;
    logic [31:0] TX_data_O;
    logic        TX_read_ack_I = 1'b0;
    logic        Active_tx_I = 1'b0;
    logic        TX_error_I = 1'b0;
`ifdef ZBT_TX_CHECKSUM_EN
    logic [31:0] Checksum_O;
`endif

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int ready_mode = 0;
    logic [23:0] base = '0;
    logic [7:0]  salt = '0;
    logic        p_v = 1'b0;
    logic [23:0] p_a = '0;
    int m_count = 0;
    int m_pending = 0;
    bit occ_chk = 1'b0;

    zbt_eth_tx_streamer #(
        .PKT_WORDS   (PKT_WORDS),
        .FIFO_DEPTH  (FIFO_DEPTH),
        .ZBT_LATENCY (ZBT_LATENCY),
        .GAP_CYCLES  (GAP_CYCLES)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .Start_I       (Start_I),
        .Range_begin_I (Range_begin_I),
        .Range_end_I   (Range_end_I),
        .Busy_O        (Busy_O),
        .Done_O        (Done_O),
        .Error_O       (Error_O),
        .ZBT_ready_I   (ZBT_ready_I),
        .Read_req_O    (Read_req_O),
        .Address_O     (Address_O),
        .Read_data_I   (Read_data_I),
        .Read_valid_I  (Read_valid_I),
        .Start_send_O  (Start_send_O),
        .Pkt_begin_O   (Pkt_begin_O),
        .Pkt_end_O     (Pkt_end_O),
        .TX_data_O     (TX_data_O),
        .TX_read_ack_I (TX_read_ack_I),
        .Active_tx_I   (Active_tx_I),
        .TX_error_I    (TX_error_I)
`ifdef ZBT_TX_CHECKSUM_EN
        ,
        .Checksum_O    (Checksum_O)
`endif
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc++;

    function automatic logic [31:0] word_of(input logic [23:0] a);
        return {salt, 24'h0} + 32'(a - base) + 32'd1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clock) begin
        ZBT_ready_I = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? (cyc % 4 == 0) : 1'b0;
    end

    // ZBT memory: an accepted read returns its word ZBT_LATENCY clocks later.
    always @(posedge clock) begin
        logic        a;
        logic [23:0] ad;
        a  = Read_req_O & ZBT_ready_I;
        ad = Address_O;
        if (Read_valid_I) begin
            m_count++;
            if (m_pending > 0) m_pending--;
        end
        if (TX_read_ack_I && m_count > 0) m_count--;
        if (a) m_pending++;
        #1;
        Read_valid_I = p_v;
        Read_data_I  = p_v ? word_of(p_a) : '0;
        p_v = a;
        p_a = ad;
    end

    always @(negedge clock) begin
        if (occ_chk) chk("occupancy_le_depth", 64'((m_count + m_pending) <= FIFO_DEPTH), 64'd1);
    end

    task automatic wait_send(input int budget);
        int n = 0;
        while (Start_send_O !== 1'b1 && n < budget) begin
            @(negedge clock);
            n++;
        end
        chk("start_send_seen", Start_send_O, 1);
    endtask

    task automatic pulse_start(input logic [23:0] b, input logic [23:0] e);
        Range_begin_I = b;
        Range_end_I   = e;
        Start_I = 1'b1;
        @(negedge clock);
        Start_I = 1'b0;
    endtask

    task automatic run_xfer(input logic [23:0] b, input logic [23:0] e,
                            input int gmin, input int gmax, input logic [7:0] s);
        longint pb[$];
        longint pe[$];
        logic [31:0] sum = '0;
        int last_fall = 0;
        int n;
        base = b;
        salt = s;
        for (longint a = b; a <= longint'(e); a += PKT_WORDS) begin
            pb.push_back(a);
            pe.push_back((a + PKT_WORDS - 1 > longint'(e)) ? longint'(e) : a + PKT_WORDS - 1);
        end
        m_count = 0;
        m_pending = 0;
        occ_chk = 1'b1;
        pulse_start(b, e);
        chk("busy_after_start", Busy_O, 1);
        pulse_start(~b, e);
        chk("restart_ignored", Error_O, 0);
        for (int p = 0; p < pb.size(); p++) begin
            wait_send(4000);
            if (Start_send_O !== 1'b1) begin
                occ_chk = 1'b0;
                return;
            end
            if (p > 0) chk("gap_before_send", 64'((cyc - last_fall) >= GAP_CYCLES), 64'd1);
            chk("pkt_begin", Pkt_begin_O, pb[p]);
            chk("pkt_end", Pkt_end_O, pe[p]);
            Active_tx_I = 1'b1;
            for (longint a = pb[p]; a <= pe[p]; a++) begin
                repeat ($urandom_range(gmin, gmax)) @(negedge clock);
                chk("tx_data", TX_data_O, word_of(24'(a)));
                sum += word_of(24'(a));
                TX_read_ack_I = 1'b1;
                @(negedge clock);
                TX_read_ack_I = 1'b0;
            end
            chk("pkt_end_stable", Pkt_end_O, pe[p]);
            chk("no_error_in_pkt", Error_O, 0);
            Active_tx_I = 1'b0;
            last_fall = cyc;
        end
        n = 0;
        while (Done_O !== 1'b1 && n < GAP_CYCLES + 100) begin
            @(negedge clock);
            n++;
        end
        chk("done_pulse", Done_O, 1);
        chk("done_delay", n, GAP_CYCLES + 1);
`ifdef ZBT_TX_CHECKSUM_EN
        chk("checksum", Checksum_O, sum);
`endif
        @(negedge clock);
        chk("done_one_clock", Done_O, 0);
        chk("busy_after_done", Busy_O, 0);
        chk("no_req_after_done", Read_req_O, 0);
        chk("fifo_empty_after_done", TX_data_O, 0);
        occ_chk = 1'b0;
    endtask

    initial begin
        int words;
        repeat (3) @(negedge clock);
        chk("rst_busy", Busy_O, 0);
        chk("rst_done", Done_O, 0);
        chk("rst_error", Error_O, 0);
        chk("rst_req", Read_req_O, 0);
        chk("rst_addr", Address_O, 0);
        chk("rst_send", Start_send_O, 0);
        chk("rst_pkt_begin", Pkt_begin_O, 0);
        chk("rst_pkt_end", Pkt_end_O, 0);
        chk("rst_tx_data", TX_data_O, 0);
        reset = 1'b0;
        @(negedge clock);

        run_xfer(24'h000100, 24'h000107, 2, 2, 8'($urandom));
        run_xfer(24'h000000, 24'h00020F, 1, 3, 8'($urandom));

        ready_mode = 1;
        run_xfer(24'h004000, 24'h00401F, 8, 8, 8'($urandom));
        ready_mode = 0;

        pulse_start(24'h000200, 24'h0001FF);
        chk("bad_range_error", Error_O, 1);
        chk("bad_range_busy", Busy_O, 0);
        @(negedge clock);
        chk("bad_range_error_once", Error_O, 0);

        base = 24'h003000;
        salt = 8'($urandom);
        m_count = 0;
        m_pending = 0;
        pulse_start(24'h003000, 24'h00300F);
        wait_send(200);
        ready_mode = 2;
        Active_tx_I = 1'b1;
        repeat (6) @(negedge clock);
        words = m_count;
        for (int k = 0; k < words; k++) begin
            chk("underrun_data", TX_data_O, word_of(24'h003000 + 24'(k)));
            TX_read_ack_I = 1'b1;
            @(negedge clock);
            TX_read_ack_I = 1'b0;
            @(negedge clock);
        end
        TX_read_ack_I = 1'b1;
        @(negedge clock);
        TX_read_ack_I = 1'b0;
        chk("underrun_error", Error_O, 1);
        chk("underrun_busy", Busy_O, 0);
        chk("underrun_fifo_empty", TX_data_O, 0);
        Active_tx_I = 1'b0;
        ready_mode = 0;
        repeat (5) @(negedge clock);

        base = 24'h005000;
        salt = 8'($urandom);
        m_count = 0;
        m_pending = 0;
        pulse_start(24'h005000, 24'h00503F);
        wait_send(200);
        Active_tx_I = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            chk("txerr_data", TX_data_O, word_of(24'h005000 + 24'(k)));
            TX_read_ack_I = 1'b1;
            @(negedge clock);
            TX_read_ack_I = 1'b0;
        end
        TX_error_I = 1'b1;
        @(negedge clock);
        TX_error_I = 1'b0;
        chk("txerr_error", Error_O, 1);
        chk("txerr_busy", Busy_O, 0);
        chk("txerr_fifo_flushed", TX_data_O, 0);
        Active_tx_I = 1'b0;
        repeat (5) @(negedge clock);
        run_xfer(24'h006000, 24'h006009, 1, 2, 8'($urandom));

        pulse_start(24'h007000, 24'h0070FF);
        repeat (10) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("midrst_busy", Busy_O, 0);
        chk("midrst_req", Read_req_O, 0);
        chk("midrst_tx_data", TX_data_O, 0);
        repeat (5) @(negedge clock);

        run_xfer(24'hFFFFFC, 24'hFFFFFF, 1, 2, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
